// File: rtl/aes_pkg.sv
// Shared AES definitions: S-box, key-schedule helpers, round transforms on
// the packed 128-bit state, and the cipher FSM state type.
// Packing: column c = data[32*c +: 32], byte r of column c = data[32*c+8*r +: 8].
package aes_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} cipher_state_t;

  // Forward S-box; entry 0 is the most significant byte of the literal.
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

  // Byte 0 of the result is byte 1 of the input.
  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[7:0], w[31:8]};
  endfunction

  // Round constant for key-schedule step i (1-based).
  function automatic logic [7:0] rcon(input logic [3:0] i);
    logic [7:0] r;
    r = 8'h01;
    for (int j = 1; j < 10; j++)
      if (j < int'(i)) r = xtime(r);
    return r;
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++) o[8*i +: 8] = SBOX[s[8*i +: 8]];
    return o;
  endfunction

  // Row r rotates left by r columns.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[32*c + 8*r +: 8] = s[32*((c + r) % 4) + 8*r +: 8];
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[32*c +: 8];
      a1 = s[32*c + 8 +: 8];
      a2 = s[32*c + 16 +: 8];
      a3 = s[32*c + 24 +: 8];
      o[32*c +: 8]      = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[32*c + 8 +: 8]  = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[32*c + 16 +: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[32*c + 24 +: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_cipher_iter_round.sv
// One combinational AES encryption round. The final round skips MixColumns.
module aes_round
  import aes_pkg::*;
(
  input  logic [127:0]     state_in,
  input  logic [3:0][31:0] round_key,
  input  logic             final_round,
  output logic [127:0]     state_out
);

  logic [127:0] shifted;

  // SubBytes and ShiftRows, optional MixColumns, then AddRoundKey.
  always_comb begin
    shifted   = shift_rows(sub_bytes(state_in));
    state_out = (final_round ? shifted : mix_columns(shifted)) ^ round_key;
  end

endmodule

// File: rtl/aes_cipher_iter.sv
// Iterative AES forward cipher: one round per clock, Nr+1 clocks per block,
// valid/ready on both sides, busy while rounds are in flight.
module aes_cipher_iter
  import aes_pkg::*;
#(
  parameter int NK = 4,
  parameter int NR = NK + 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [31:0]  rkey [4*(NR+1)],
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  localparam int RW = $clog2(NR + 1);

  cipher_state_t    cs, cs_d;
  logic [RW-1:0]    rnd, rnd_d;
  logic [127:0]     state_q, state_d;
  logic [3:0][31:0] key0, round_key;
  logic [127:0]     round_out;
  logic             last_round;

  assign key0       = {rkey[3], rkey[2], rkey[1], rkey[0]};
  assign last_round = (rnd == RW'(NR));

  // Select the four key words of the round currently being computed.
  always_comb begin
    round_key = '0;
    for (int k = 0; k <= NR; k++)
      if (rnd == RW'(k))
        round_key = {rkey[4*k+3], rkey[4*k+2], rkey[4*k+1], rkey[4*k]};
  end

  aes_round u_round (
    .state_in    (state_q),
    .round_key   (round_key),
    .final_round (last_round),
    .state_out   (round_out)
  );

  // State register, round counter and data register.
  // NOTE: non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cs      <= IDLE;
      rnd     <= '0;
      state_q <= '0;
    end else begin
      cs      <= cs_d;
      rnd     <= rnd_d;
      state_q <= state_d;
    end
  end

  // Next-state, datapath select and handshake outputs.
  always_comb begin
    // NOTE: defaults first so no path through the case leaves a latch behind.
    cs_d      = cs;
    rnd_d     = rnd;
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (cs)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_d = in_data ^ key0;
          rnd_d   = RW'(1);
          cs_d    = RUN;
        end
      end
      RUN: begin
        busy    = 1'b1;
        state_d = round_out;
        rnd_d   = rnd + RW'(1);
        if (last_round) cs_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) begin
          if (in_valid) begin
            // Output consumed and the next block accepted in the same cycle.
            state_d = in_data ^ key0;
            rnd_d   = RW'(1);
            cs_d    = RUN;
          end else begin
            rnd_d = '0;
            cs_d  = IDLE;
          end
        end
      end
      default: begin
        rnd_d = '0;
        cs_d  = IDLE;
      end
    endcase
  end

  assign out_data = state_q;

endmodule

// File: doc/aes_cipher_iter.md
Name: aes_cipher_iter

Overview:
Iterative AES forward cipher that consumes the round-key array from aes_key_expansion and encrypts one 128-bit block in Nr+1 clocks, one round per clock. It sits directly downstream of key expansion.
- Upstream: valid/ready input handshake for plaintext.
- Downstream: valid/ready output handshake for ciphertext.
- A busy output lets the system gate key reloads.

Parameters:
Nk, 4, key length in 32-bit words (4/6/8 for AES-128/192/256)
Nr, Nk+6, number of rounds

Ports:
clk  input  1  clock; all flops rising-edge
reset  input  1  asynchronous, active-high reset
rkey  input  32 x 4*(Nr+1)  round-key words from key expansion; word w = rkey[w]
in_valid  input  1  plaintext valid
in_ready  output  1  block can accept plaintext this cycle
in_data  input  128  plaintext
out_valid  output  1  ciphertext valid
out_ready  input  1  downstream accepts ciphertext
out_data  output  128  ciphertext
busy  output  1  a block is in flight (RUN state); rkey must be stable while high

Behaviour:
- Data packing, state and key words identical: column c = data[32*c+:32]; byte r of column c = data[32*c+8*r+:8].
- Round keys: round k uses rkey[4k..4k+3]; column c is XORed with rkey[4k+c].
- Reset values: FSM=IDLE, round counter=0, state register=0, out_valid=0, out_data=0, busy=0, in_ready=1.
- FSM states IDLE, RUN, DONE:
  - IDLE: in_ready=1. On in_valid: state <= in_data ^ round-key 0; rnd <= 1; go to RUN.
  - RUN: each cycle state <= round(state, rnd), then rnd <= rnd+1.
    - Rounds 1..Nr-1: SubBytes, ShiftRows, MixColumns, AddRoundKey.
    - Round Nr: skip MixColumns.
    - After round Nr: go to DONE.
  - DONE: out_valid=1, out_data=state.
    - Hold out_data stable until out_ready.
    - On out_ready with no new input: go to IDLE.
- in_ready = (FSM==IDLE) | (FSM==DONE & out_ready). This allows back-to-back blocks.
  - In DONE with out_ready & in_valid in the same cycle: the output is consumed and the new block is accepted (AddRoundKey 0 applied); go directly to RUN.
- Latency: acceptance at cycle t gives out_valid=1 at cycle t+Nr+1 (t+11 for Nk=4, t+15 for Nk=8).
  - Maximum throughput: one block per Nr+1 cycles.
- Round counter width: clog2(Nr+1) bits.
  - Compare against Nr to leave RUN; the counter never wraps.
  - Counter value is don't-care outside RUN but is reset to 0 on entry to IDLE.
- busy=1 only in RUN.
  - Changing rkey while busy is illegal; the bench asserts it never happens.
  - rkey may change freely in IDLE and DONE, because out_data is already registered.
- in_valid while in_ready=0 is ignored. The upstream must hold in_valid and in_data until the handshake completes.
- Reset asserted mid-operation: the block is immediately abandoned and all outputs return to reset values. No partial ciphertext is emitted.
- in_data is not sampled outside the accepting cycle.

Decomposition:
- aes_pkg (shared) holds:
  - Existing SBOX, SubWord, RotWord, RCON.
  - New functions SubBytes, ShiftRows, MixColumns, xtime on the 128-bit state, using the packing above.
  - New enum cipher_state_t {IDLE, RUN, DONE}.
- One combinational sub-module, aes_round: input state, 4 key words, and a final flag (bypass MixColumns); output next state.
- aes_cipher_iter instantiates one aes_round and a 4-word key mux indexed by rnd.
- Flops use the team flop macros with asynchronous reset.

Test Plan:
- Reference vector, Nk=4: rkey from key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff -> out_valid at accept+11, ct 69c4e0d86a7b0430d8cdb78070b4c55a.
- Reference vector, Nk=8: key 000102...1e1f, same pt -> out_valid at accept+15, ct 8ea2b7ca516745bfeafc49904b496089.
- Backpressure: out_ready=0 for 20 cycles after completion -> out_data stable, in_ready=0, busy=0. Then out_ready=1 -> out_valid falls next cycle.
- Back-to-back: in_valid held high with out_ready=1 and two plaintexts -> second accepted in the first's DONE cycle. Ciphertexts arrive 11 cycles apart (Nk=4), both correct.
- Reset at round 5 -> out_valid=0, out_data=0, in_ready=1 immediately. A fresh block afterwards gives the correct ciphertext.
- Random: 1000 random key/pt pairs against a C model via DPI, with random in_valid/out_ready gaps -> all match, and no rkey change while busy.
